// File: rtl/mem_loader.sv
// mem_loader: session controller that streams words into an instruction SRAM
// and a data SRAM, holds the processor enable for a programmed number of
// cycles, then reads data words back out on a stream.
//
// Handshakes: a transfer on either stream happens in any cycle where valid and
// ready are both 1 at the rising edge of clk. A producer holds valid and its
// payload stable until the transfer; ready may change freely.
//
// Ports
//   clk, arst_n                  clock (rising edge), async active-low reset
//   start                        one-cycle session request, honoured in IDLE
//   imem_words, dmem_words       words to load into each memory
//   run_cycles                   cycles cpu_enable is held high
//   dump_words                   data words read back on the dump stream
//   s_valid/s_data/s_ready       load stream (sink)
//   m_valid/m_data/m_ready       dump stream (source)
//   *_ext                        instruction-memory SRAM port (byte address)
//   *_ext_2                      data-memory SRAM port (byte address)
//   cpu_enable, busy, done       run enable, session active, completion pulse
//   fsm_state                    current FSM state, for observation
module mem_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [9:0]  imem_words,
  input  logic [10:0] dmem_words,
  input  logic [15:0] run_cycles,
  input  logic [10:0] dump_words,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [31:0] wdata_ext_2,
  input  logic [31:0] rdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_I   = 3'd1;
  localparam logic [2:0] LOAD_D   = 3'd2;
  localparam logic [2:0] RUN      = 3'd3;
  localparam logic [2:0] DUMP_RD  = 3'd4;
  localparam logic [2:0] DUMP_OUT = 3'd5;
  localparam logic [2:0] FINISH   = 3'd6;

  localparam logic [31:0] IMEM_LIM = IMEM_DEPTH;
  localparam logic [31:0] DMEM_LIM = DMEM_DEPTH;

  logic [2:0]  state;
  logic [10:0] idx;        // word index within the current phase
  logic [10:0] i_cnt;
  logic [10:0] d_cnt;
  logic [10:0] u_cnt;
  logic [15:0] run_left;   // RUN cycles still to go, loaded on start
  logic [31:0] m_data_q;
  logic        fresh;      // first DUMP_OUT cycle: SRAM read data is on rdata_ext_2

  // Instruction-memory read data is never needed by the loader.
  logic unused_rdata;
  assign unused_rdata = ^rdata_ext;

  // Clamp requested counts to the memory depths.
  logic [31:0] imem_req, dmem_req, dump_req;
  logic [10:0] imem_clamp, dmem_clamp, dump_clamp;
  assign imem_req   = {22'd0, imem_words};
  assign dmem_req   = {21'd0, dmem_words};
  assign dump_req   = {21'd0, dump_words};
  assign imem_clamp = (imem_req > IMEM_LIM) ? IMEM_LIM[10:0] : imem_req[10:0];
  assign dmem_clamp = (dmem_req > DMEM_LIM) ? DMEM_LIM[10:0] : dmem_req[10:0];
  assign dump_clamp = (dump_req > DMEM_LIM) ? DMEM_LIM[10:0] : dump_req[10:0];

  // First phase after 'from' whose count is nonzero; FINISH if none remain.
  function automatic logic [2:0] pick(input logic [2:0]  from,
                                      input logic [10:0] ni,
                                      input logic [10:0] nd,
                                      input logic [15:0] nr,
                                      input logic [10:0] nu);
    logic [2:0] res;
    res = FINISH;
    if ((from == IDLE || from == LOAD_I || from == LOAD_D || from == RUN) && nu != 11'd0)
      res = DUMP_RD;
    if ((from == IDLE || from == LOAD_I || from == LOAD_D) && nr != 16'd0)
      res = RUN;
    if ((from == IDLE || from == LOAD_I) && nd != 11'd0)
      res = LOAD_D;
    if (from == IDLE && ni != 11'd0)
      res = LOAD_I;
    return res;
  endfunction

  logic in_li, in_ld, hs;
  logic [31:0] word_addr;
  assign in_li     = (state == LOAD_I);
  assign in_ld     = (state == LOAD_D);
  assign hs        = s_valid & s_ready;
  assign word_addr = {19'd0, idx, 2'b00};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      idx      <= '0;
      i_cnt    <= '0;
      d_cnt    <= '0;
      u_cnt    <= '0;
      run_left <= '0;
      m_data_q <= '0;
      fresh    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i_cnt    <= imem_clamp;
            d_cnt    <= dmem_clamp;
            u_cnt    <= dump_clamp;
            run_left <= run_cycles;
            idx      <= '0;
            state    <= pick(IDLE, imem_clamp, dmem_clamp, run_cycles, dump_clamp);
          end
        end
        LOAD_I: begin
          if (hs) begin
            if (idx == i_cnt - 11'd1) begin
              idx   <= '0;
              state <= pick(LOAD_I, i_cnt, d_cnt, run_left, u_cnt);
            end else begin
              idx <= idx + 11'd1;
            end
          end
        end
        LOAD_D: begin
          if (hs) begin
            if (idx == d_cnt - 11'd1) begin
              idx   <= '0;
              state <= pick(LOAD_D, i_cnt, d_cnt, run_left, u_cnt);
            end else begin
              idx <= idx + 11'd1;
            end
          end
        end
        RUN: begin
          run_left <= run_left - 16'd1;
          if (run_left == 16'd1) state <= pick(RUN, i_cnt, d_cnt, run_left, u_cnt);
        end
        DUMP_RD: begin
          state <= DUMP_OUT;
          fresh <= 1'b1;
        end
        DUMP_OUT: begin
          fresh <= 1'b0;
          if (fresh) m_data_q <= rdata_ext_2;
          if (m_ready) begin
            if (idx == u_cnt - 11'd1) begin
              idx   <= '0;
              state <= FINISH;
            end else begin
              idx   <= idx + 11'd1;
              state <= DUMP_RD;
            end
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign s_ready     = in_li | in_ld;
  assign wen_ext     = hs & in_li;
  assign addr_ext    = in_li ? word_addr : '0;
  assign wdata_ext   = wen_ext ? s_data : '0;
  assign ren_ext     = 1'b0;

  assign wen_ext_2   = hs & in_ld;
  assign ren_ext_2   = (state == DUMP_RD);
  assign addr_ext_2  = (in_ld | ren_ext_2) ? word_addr : '0;
  assign wdata_ext_2 = wen_ext_2 ? s_data : '0;

  // The SRAM output is only guaranteed in the cycle after the read, so the
  // first DUMP_OUT cycle passes it through and later cycles use the copy.
  assign m_valid     = (state == DUMP_OUT);
  assign m_data      = fresh ? rdata_ext_2 : m_data_q;

  assign cpu_enable  = (state == RUN);
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign fsm_state   = state;

endmodule
